// File: rtl/safebox_pkg.sv
// Shared safe-box constants: key codes, blank digit code and FSM state type.
// Optional feature macro: PW_CHANGE_EN adds the NEWPW state.
package safebox_pkg;

  localparam logic [4:0] KEY_ENTER   = 5'd16;
  localparam logic [4:0] KEY_BSP     = 5'd17;
  localparam logic [4:0] KEY_CLR     = 5'd18;
  localparam logic [4:0] KEY_SHOW    = 5'd19;
  localparam logic [4:0] KEY_SET     = 5'd20;
  localparam logic [4:0] DIGIT_BLANK = 5'h1F;

`ifdef PW_CHANGE_EN
  typedef enum logic [2:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_LOCKED, ST_NEWPW} state_t;
`else
  typedef enum logic [2:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_LOCKED} state_t;
`endif

endpackage

// File: rtl/safebox_timer.sv
// Shared OPEN/LOCKED timer: 29-bit saturating up-counter, terminal count chosen by sel_lock.
// Used by password_entry regardless of PW_CHANGE_EN.
module safebox_timer #(
  parameter logic [28:0] OPEN_TC = 29'd249_999_999,
  parameter logic [28:0] LOCK_TC = 29'd499_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  input  logic sel_lock,
  output logic done
);

  logic [28:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (run && cnt != '1)   cnt <= cnt + 29'd1;
  end

  assign done = run && (cnt == (sel_lock ? LOCK_TC : OPEN_TC));

endmodule

// File: rtl/password_entry.sv
// Keypad entry buffer, password compare, retry/lockout FSM for the 4-digit safe box.
// Define PW_CHANGE_EN to enable changing the password from the OPEN state (NEWPW).
module password_entry
  import safebox_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PW  = 16'h1234,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned OPEN_CYCLES = 250_000_000,
  parameter int unsigned LOCK_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic [4:0] p0,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic [4:0] p3,
  output logic       show_digits,
  output logic       unlock,
  output logic       locked,
  output logic       err_pulse,
  output logic [2:0] tries
);

  localparam logic [2:0]  MAX_T   = 3'(MAX_TRIES);
  localparam logic [28:0] OPEN_TC = 29'(OPEN_CYCLES - 1);
  localparam logic [28:0] LOCK_TC = 29'(LOCK_CYCLES - 1);

  state_t      state, state_n;
  logic [4:0]  p [4];
  logic [4:0]  p_n [4];
  logic [2:0]  cnt, cnt_n, cnt_m1;
  logic [2:0]  tries_n;
  logic        show_n, err_n, clr_buf, edit_st, tmr_done;
  logic [15:0] stored_pw, entered;

`ifdef PW_CHANGE_EN
  logic [15:0] pw_q, pw_n;
  assign stored_pw = pw_q;
  assign edit_st   = (state == ST_ENTRY) || (state == ST_NEWPW);
`else
  assign stored_pw = DEFAULT_PW;
  assign edit_st   = (state == ST_ENTRY);
`endif

  assign entered = {p[0][3:0], p[1][3:0], p[2][3:0], p[3][3:0]};
  assign cnt_m1  = cnt - 3'd1;
  assign {p0, p1, p2, p3} = {p[0], p[1], p[2], p[3]};

  safebox_timer #(.OPEN_TC(OPEN_TC), .LOCK_TC(LOCK_TC)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_n != state),
    .run      ((state == ST_OPEN) || (state == ST_LOCKED)),
    .sel_lock (state == ST_LOCKED),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ENTRY;
      for (int unsigned i = 0; i < 4; i++) p[i] <= DIGIT_BLANK;
      cnt         <= '0;
      show_digits <= 1'b0;
      unlock      <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      tries       <= '0;
`ifdef PW_CHANGE_EN
      pw_q        <= DEFAULT_PW;
`endif
    end else begin
      state       <= state_n;
      p           <= p_n;
      cnt         <= cnt_n;
      show_digits <= show_n;
      unlock      <= (state_n == ST_OPEN);
      locked      <= (state_n == ST_LOCKED);
      err_pulse   <= err_n;
      tries       <= tries_n;
`ifdef PW_CHANGE_EN
      pw_q        <= pw_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    p_n     = p;
    cnt_n   = cnt;
    show_n  = show_digits;
    tries_n = tries;
    err_n   = 1'b0;
    clr_buf = 1'b0;
`ifdef PW_CHANGE_EN
    pw_n    = pw_q;
`endif

    // Buffer editing is identical in ENTRY and NEWPW, so it is handled once here.
    if (key_valid && edit_st) begin
      if (key_code < KEY_ENTER) begin
        if (cnt < 3'd4) begin
          p_n[cnt[1:0]] = key_code;
          cnt_n         = cnt + 3'd1;
        end
      end else if (key_code == KEY_BSP) begin
        if (cnt != '0) begin
          p_n[cnt_m1[1:0]] = DIGIT_BLANK;
          cnt_n            = cnt_m1;
        end
      end else if (key_code == KEY_CLR) begin
        clr_buf = 1'b1;
      end else if (key_code == KEY_SHOW) begin
        show_n = ~show_digits;
      end
    end

    case (state)
      ST_ENTRY:
        if (key_valid && key_code == KEY_ENTER && cnt == 3'd4) state_n = ST_CHECK;
      ST_CHECK: begin
        clr_buf = 1'b1;
        if (entered == stored_pw) begin
          state_n = ST_OPEN;
          tries_n = '0;
        end else begin
          err_n   = 1'b1;
          tries_n = tries + 3'd1;
          state_n = (tries_n == MAX_T) ? ST_LOCKED : ST_ENTRY;
        end
      end
      ST_OPEN:
        if (tmr_done || (key_valid && (key_code == KEY_ENTER || key_code == KEY_CLR)))
          state_n = ST_ENTRY;
`ifdef PW_CHANGE_EN
        else if (key_valid && key_code == KEY_SET) begin
          state_n = ST_NEWPW;
          clr_buf = 1'b1;
        end
`endif
      ST_LOCKED:
        if (tmr_done) begin
          state_n = ST_ENTRY;
          tries_n = '0;
        end
`ifdef PW_CHANGE_EN
      ST_NEWPW:
        if (key_valid) begin
          if (key_code == KEY_ENTER && cnt == 3'd4) begin
            pw_n    = entered;
            clr_buf = 1'b1;
            state_n = ST_ENTRY;
          end else if (key_code == KEY_CLR && cnt == '0) begin
            state_n = ST_ENTRY;
          end
        end
`endif
      default: state_n = ST_ENTRY;
    endcase

    if (clr_buf) begin
      for (int unsigned i = 0; i < 4; i++) p_n[i] = DIGIT_BLANK;
      cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_password_entry.sv
// Self-checking bench for password_entry: directed scenarios plus random keys vs a queue-based model.
// Honours PW_CHANGE_EN when defined for the build.
module tb_password_entry;

  localparam logic [15:0] PW     = 16'h1234;
  localparam int          MAXT   = 3;
  localparam int          OPEN_C = 20;
  localparam int          LOCK_C = 50;
  localparam logic [31:0] RST_OUTS = {5'b0, {4{5'h1F}}, 7'b0};

  localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_LOCK = 3, M_NEWPW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = '0;
  logic [4:0] p0, p1, p2, p3;
  logic       show_digits, unlock, locked, err_pulse;
  logic [2:0] tries;

  password_entry #(
    .DEFAULT_PW (PW),
    .MAX_TRIES  (MAXT),
    .OPEN_CYCLES(OPEN_C),
    .LOCK_CYCLES(LOCK_C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .p0         (p0),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .show_digits(show_digits),
    .unlock     (unlock),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .tries      (tries)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: digit queue, remaining-cycle countdown, plain counters.
  int          m_mode;
  int          m_left;
  int          m_buf[$];
  bit          m_show;
  bit          m_err;
  int          m_tries;
  logic [15:0] m_pw;

  task automatic model_reset();
    m_mode = M_ENTRY; m_left = 0; m_buf.delete();
    m_show = 0; m_err = 0; m_tries = 0; m_pw = PW;
  endtask

  function automatic logic [15:0] buf_value();
    int v = 0;
    foreach (m_buf[i]) v = v * 16 + m_buf[i];
    return 16'(v);
  endfunction

  task automatic model_step(input bit v, input int c);
    m_err = 0;
    case (m_mode)
      M_ENTRY, M_NEWPW: if (v) begin
        if (c < 16) begin
          if (m_buf.size() < 4) m_buf.push_back(c);
        end else if (c == 17) begin
          if (m_buf.size() > 0) void'(m_buf.pop_back());
        end else if (c == 18) begin
          if (m_mode == M_NEWPW && m_buf.size() == 0) m_mode = M_ENTRY;
          m_buf.delete();
        end else if (c == 19) begin
          m_show = !m_show;
        end else if (c == 16 && m_buf.size() == 4) begin
          if (m_mode == M_ENTRY) m_mode = M_CHECK;
          else begin
            m_pw = buf_value();
            m_buf.delete();
            m_mode = M_ENTRY;
          end
        end
      end
      M_CHECK: begin
        if (buf_value() == m_pw) begin
          m_mode = M_OPEN; m_left = OPEN_C; m_tries = 0;
        end else begin
          m_err = 1;
          m_tries++;
          if (m_tries == MAXT) begin m_mode = M_LOCK; m_left = LOCK_C; end
          else m_mode = M_ENTRY;
        end
        m_buf.delete();
      end
      M_OPEN: begin
        m_left--;
        if (m_left == 0 || (v && (c == 16 || c == 18))) m_mode = M_ENTRY;
`ifdef PW_CHANGE_EN
        else if (v && c == 20) begin m_mode = M_NEWPW; m_buf.delete(); end
`endif
      end
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_ENTRY; m_tries = 0; end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] exp_outs();
    logic [4:0] d[4];
    for (int i = 0; i < 4; i++) d[i] = (i < m_buf.size()) ? 5'(m_buf[i]) : 5'h1F;
    return {5'b0, d[0], d[1], d[2], d[3], m_show, m_mode == M_OPEN, m_mode == M_LOCK,
            m_err, 3'(m_tries)};
  endfunction

  function automatic logic [31:0] dut_outs();
    return {5'b0, p0, p1, p2, p3, show_digits, unlock, locked, err_pulse, tries};
  endfunction

  task automatic tick(input bit v, input int c);
    key_valid = v;
    key_code  = 5'(c);
    @(posedge clk);
    model_step(v, c);
    #1;
    key_valid = 1'b0;
    check("cycle_outs", dut_outs(), exp_outs());
  endtask

  task automatic press(input int c);
    tick(1'b1, c);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0);
  endtask

  task automatic type_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) press(int'(code[15 - 4 * i -: 4]));
    press(16);
  endtask

  // Called #1 after a posedge: asserts reset and checks before the next edge arrives.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check(tag, dut_outs(), RST_OUTS);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int cnt_hi;
    int ds[6] = '{0, 1, 2, 3, 4, 9};
    model_reset();
    #22;
    check("reset", dut_outs(), RST_OUTS);
    rst_n = 1'b1;

    // 1: correct code, 2-cycle latency, 20-cycle open window
    press(1); press(2); press(3); press(4); press(16);
    check("t1_lat1", 32'(unlock), 32'd0);
    idle(1);
    check("t1_unlock", 32'(unlock), 32'd1);
    check("t1_buf", {12'b0, p0, p1, p2, p3}, {12'b0, {4{5'h1F}}});
    cnt_hi = 1;
    for (int i = 0; i < 40 && unlock; i++) begin
      idle(1);
      if (unlock) cnt_hi++;
    end
    check("t1_open_len", 32'(cnt_hi), 32'(OPEN_C));

    // 2: backspace behaviour
    press(17);
    check("t2_bsp0", {12'b0, p0, p1, p2, p3}, {12'b0, {4{5'h1F}}});
    press(1); press(2); press(9); press(17); press(3); press(4);
    check("t2_buf", {12'b0, p0, p1, p2, p3}, {12'b0, 5'd1, 5'd2, 5'd3, 5'd4});
    press(16); idle(1);
    check("t2_unlock", 32'(unlock), 32'd1);
    press(18);
    check("t2_clr_exit", 32'(unlock), 32'd0);

    // 4: overflow digit and short ENTER
    press(1); press(2); press(3); press(4); press(5);
    check("t4_full", {12'b0, p0, p1, p2, p3}, {12'b0, 5'd1, 5'd2, 5'd3, 5'd4});
    press(18); press(1); press(2); press(3); press(16); idle(1);
    check("t4_short", {29'b0, err_pulse, tries[1:0]}, 32'd0);
    press(19);
    check("t4_show", 32'(show_digits), 32'd1);
    press(18);

    // 3: three failures -> lockout
    for (int k = 1; k <= 3; k++) begin
      type_code(16'h0000);
      idle(1);
      check("t3_err", {28'b0, err_pulse, tries}, {28'b0, 1'b1, 3'(k)});
    end
    check("t3_locked", 32'(locked), 32'd1);
    cnt_hi = 1;
    for (int i = 0; i < 5; i++) begin
      press((i < 4) ? i + 1 : 16);
      if (locked) cnt_hi++;
    end
    for (int i = 0; i < 100 && locked; i++) begin
      idle(1);
      if (locked) cnt_hi++;
    end
    check("t3_lock_len", 32'(cnt_hi), 32'(LOCK_C));
    check("t3_tries0", 32'(tries), 32'd0);
    type_code(PW); idle(1);
    check("t3_reopen", 32'(unlock), 32'd1);

    // 5: async reset mid-OPEN and mid-LOCKED
    idle(3);
    async_reset("t5_rst_open");
    for (int k = 0; k < 3; k++) begin type_code(16'h4321); idle(1); end
    idle(5);
    check("t5_pre_lock", 32'(locked), 32'd1);
    async_reset("t5_rst_lock");

    // 6: password change (or SET ignored)
    type_code(PW); idle(1);
    press(20);
`ifdef PW_CHANGE_EN
    check("t6_set", 32'(unlock), 32'd0);
    type_code(16'h9876);
    type_code(PW); idle(1);
    check("t6_old_err", 32'(err_pulse), 32'd1);
    type_code(16'h9876); idle(1);
    check("t6_new_open", 32'(unlock), 32'd1);
`else
    check("t6_set_ignored", 32'(unlock), 32'd1);
`endif
    press(18);

    // Random keys against the model
    for (int n = 0; n < 2500; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 4)       type_code(m_pw);
      else if (r < 40) idle(1);
      else if (r < 70) press(ds[$urandom_range(0, 5)]);
      else if (r < 78) press(16);
      else if (r < 84) press(17);
      else if (r < 88) press(18);
      else if (r < 92) press(19);
      else if (r < 95) press(20);
      else             press($urandom_range(21, 31));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
